// File: rtl/vx_tensor_wb_serializer.sv
// vx_tensor_wb_serializer: two-entry D-tile buffer that drains 4x4 fp32 result tiles to commit as row beats.
// Revision: 1.0
`default_nettype none

module vx_tensor_wb_serializer #(
  parameter int WID_W     = 4,
  parameter int BEAT_ROWS = 1,
  localparam int BEAT_W   = BEAT_ROWS * 4 * 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [511:0]       D_tile,
  input  logic [WID_W-1:0]   D_wid,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [BEAT_W-1:0]  out_data,
  output logic [WID_W-1:0]   out_wid,
  output logic [1:0]         out_beat,
  output logic               out_last,
  output logic [15:0]        tiles_done
);

  localparam int NBEATS          = 4 / BEAT_ROWS;
  localparam int CNT_W           = 2;
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

  typedef enum logic [CNT_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             cnt;
  occ_t             cnt_nxt;
  logic             hd;
  logic             tl;
  logic [1:0]       bc;
  logic [15:0]      done_cnt;
  logic [511:0]     tile_mem [2];
  logic [WID_W-1:0] wid_mem  [2];
  logic             enq;
  logic             fire;
  logic             drain;
  logic [8:0]       beat_off;

  // Handshake outputs come from registered occupancy only, never from ready_out.
  assign ready_in   = (cnt != TWO);
  assign valid_out  = (cnt != EMPTY);
  assign enq        = valid_in && ready_in;
  assign fire       = valid_out && ready_out;
  assign out_last   = (bc == LAST_BEAT);
  assign drain      = fire && out_last;
  assign out_beat   = bc;
  assign tiles_done = done_cnt;
  assign out_wid    = wid_mem[hd];
  assign beat_off   = 9'(32'(bc) * BEAT_W);
  assign out_data   = tile_mem[hd][beat_off +: BEAT_W];

  always_ff @(posedge clk) begin
    if (enq) begin
      tile_mem[tl] <= D_tile;
      wid_mem[tl]  <= D_wid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= EMPTY;
      hd       <= 1'b0;
      tl       <= 1'b0;
      bc       <= 2'd0;
      done_cnt <= 16'd0;
    end else begin
      cnt <= cnt_nxt;
      if (enq) begin
        tl <= ~tl;
      end
      if (drain) begin
        bc       <= 2'd0;
        hd       <= ~hd;
        done_cnt <= done_cnt + 16'd1;
      end else if (fire) begin
        bc <= bc + 2'd1;
      end
    end
  end

  // In ONE, a new tile and a last-beat drain cancel out: occupancy holds while both pointers move.
  always_comb begin
    cnt_nxt = cnt;
    case (cnt)
      EMPTY: if (enq) cnt_nxt = ONE;
      ONE: begin
        if (enq && !drain) begin
          cnt_nxt = TWO;
        end else if (drain && !enq) begin
          cnt_nxt = EMPTY;
        end
      end
      TWO:     if (drain) cnt_nxt = ONE;
      default: cnt_nxt = EMPTY;
    endcase
  end

  a_no_enq_full: assert property (@(posedge clk) disable iff (reset)
    !(valid_in && ready_in && (cnt == TWO)));

  a_beat_range: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, bc} < 3'(NBEATS)));

  a_head_hold: assert property (@(posedge clk) disable iff (reset)
    (valid_out && !ready_out) |=> (valid_out && $stable(out_data) && $stable(out_wid) && $stable(out_beat)));

endmodule

`default_nettype wire

// File: tb/tb_vx_tensor_wb_serializer.sv
// Directed bench for vx_tensor_wb_serializer: one instance per legal BEAT_ROWS, shared tile/ready stimulus.
`default_nettype none

module tb_vx_tensor_wb_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         vin;
  int           sel;
  logic [511:0] din;
  logic [3:0]   dwid;
  logic         rdy;
  logic         v1, v2, v4;

  assign v1 = vin && (sel == 0);
  assign v2 = vin && (sel == 1);
  assign v4 = vin && (sel == 2);

  logic         ri1, ri2, ri4, vo1, vo2, vo4, l1, l2, l4;
  logic [127:0] d1;
  logic [255:0] d2;
  logic [511:0] d4;
  logic [3:0]   w1, w2, w4;
  logic [1:0]   b1, b2, b4;
  logic [15:0]  t1, t2, t4;

  vx_tensor_wb_serializer #(.WID_W(4), .BEAT_ROWS(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(v1), .ready_in(ri1), .D_tile(din), .D_wid(dwid),
    .valid_out(vo1), .ready_out(rdy), .out_data(d1), .out_wid(w1), .out_beat(b1),
    .out_last(l1), .tiles_done(t1));

  vx_tensor_wb_serializer #(.WID_W(4), .BEAT_ROWS(2)) dut2 (
    .clk(clk), .reset(reset), .valid_in(v2), .ready_in(ri2), .D_tile(din), .D_wid(dwid),
    .valid_out(vo2), .ready_out(rdy), .out_data(d2), .out_wid(w2), .out_beat(b2),
    .out_last(l2), .tiles_done(t2));

  vx_tensor_wb_serializer #(.WID_W(4), .BEAT_ROWS(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(v4), .ready_in(ri4), .D_tile(din), .D_wid(dwid),
    .valid_out(vo4), .ready_out(rdy), .out_data(d4), .out_wid(w4), .out_beat(b4),
    .out_last(l4), .tiles_done(t4));

  logic         s_rdy, s_valid, s_last;
  logic [511:0] s_data;
  logic [3:0]   s_wid;
  logic [1:0]   s_beat;
  logic [15:0]  s_done;

  always_comb begin
    s_rdy = ri1; s_valid = vo1; s_last = l1; s_data = 512'(d1);
    s_wid = w1;  s_beat = b1;   s_done = t1;
    if (sel == 1) begin
      s_rdy = ri2; s_valid = vo2; s_last = l2; s_data = 512'(d2);
      s_wid = w2;  s_beat = b2;   s_done = t2;
    end else if (sel == 2) begin
      s_rdy = ri4; s_valid = vo4; s_last = l4; s_data = d4;
      s_wid = w4;  s_beat = b4;   s_done = t4;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [511:0] mk_tile(input int seed);
    logic [511:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[(r*4+c)*32 +: 32] = 32'(seed*256 + 16*r + c);
    return t;
  endfunction

  function automatic logic [511:0] exp_beat(input int seed, input int beat, input int rows);
    logic [511:0] e;
    e = '0;
    for (int k = 0; k < rows; k++)
      for (int c = 0; c < 4; c++)
        e[(k*4+c)*32 +: 32] = 32'(seed*256 + 16*(beat*rows + k) + c);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_beat(input string tag, input int seed, input int wid, input int b,
                          input int rows, input int n);
    chk({tag, "_meta"}, 512'({s_valid, s_wid, s_beat, s_last}),
        512'({1'b1, 4'(wid), 2'(b), (b == n - 1)}));
    chk({tag, "_data"}, s_data, exp_beat(seed, b, rows));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; vin = 1'b0; sel = 0; din = '0; dwid = 4'd0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta", 512'({s_valid, s_rdy, s_beat, s_last, s_done}), 512'({1'b0, 1'b1, 2'd0, 1'b0, 16'd0}));
    sel = 2;
    #1;
    chk("rst_meta_br4", 512'({s_valid, s_rdy, s_beat, s_last, s_done}), 512'({1'b0, 1'b1, 2'd0, 1'b1, 16'd0}));
    sel = 0;
    @(negedge clk) reset = 1'b0;

    // single tile, ready_out high
    din = mk_tile(0); dwid = 4'd3; vin = 1'b1;
    step(); vin = 1'b0;
    for (int b = 0; b < 4; b++) begin chk_beat("t1", 0, 3, b, 1, 4); step(); end
    chk("t1_idle", 512'(s_valid), 512'(1'b0));
    chk("t1_done", 512'(s_done), 512'(16'd1));

    // backpressure on beat 0
    rdy = 1'b0; din = mk_tile(1); dwid = 4'd5; vin = 1'b1;
    step(); vin = 1'b0;
    repeat (3) begin chk_beat("t2_hold", 1, 5, 0, 1, 4); step(); end
    rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin chk_beat("t2", 1, 5, b, 1, 4); step(); end
    chk("t2_idle_done", 512'({s_valid, s_done}), 512'({1'b0, 16'd2}));

    // fill to full, third tile held
    rdy = 1'b0; din = mk_tile(2); dwid = 4'd1; vin = 1'b1;
    step();
    chk("t3_rdy1", 512'(s_rdy), 512'(1'b1));
    din = mk_tile(3); dwid = 4'd2;
    step();
    chk("t3_full", 512'(s_rdy), 512'(1'b0));
    din = mk_tile(4); dwid = 4'd4;
    step();
    chk("t3_held", 512'(s_rdy), 512'(1'b0));
    rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin chk_beat("t3_w1", 2, 1, b, 1, 4); step(); end
    chk("t3_reopen", 512'(s_rdy), 512'(1'b1));
    for (int b = 0; b < 4; b++) begin
      chk_beat("t3_w2", 3, 2, b, 1, 4);
      step();
      if (b == 0) begin
        vin = 1'b0;
        chk("t3_refull", 512'(s_rdy), 512'(1'b0));
      end
    end
    for (int b = 0; b < 4; b++) begin chk_beat("t3_w4", 4, 4, b, 1, 4); step(); end
    chk("t3_idle_done", 512'({s_valid, s_done}), 512'({1'b0, 16'd5}));

    // enq coinciding with the head's last beat
    din = mk_tile(5); dwid = 4'd6; vin = 1'b1;
    step(); vin = 1'b0;
    for (int b = 0; b < 3; b++) begin chk_beat("t4_a", 5, 6, b, 1, 4); step(); end
    chk_beat("t4_last", 5, 6, 3, 1, 4);
    din = mk_tile(6); dwid = 4'd7; vin = 1'b1;
    chk("t4_rdy", 512'(s_rdy), 512'(1'b1));
    step(); vin = 1'b0;
    chk("t4_cnt1_rdy", 512'(s_rdy), 512'(1'b1));
    for (int b = 0; b < 4; b++) begin chk_beat("t4_b", 6, 7, b, 1, 4); step(); end
    chk("t4_idle_done", 512'({s_valid, s_done}), 512'({1'b0, 16'd7}));

    // asynchronous reset mid-drain with two tiles buffered
    din = mk_tile(7); dwid = 4'd8; vin = 1'b1;
    step();
    din = mk_tile(8); dwid = 4'd9;
    step(); vin = 1'b0;
    chk_beat("t6_b1", 7, 8, 1, 1, 4);
    chk("t6_full", 512'(s_rdy), 512'(1'b0));
    #2 reset = 1'b1;
    #1;
    chk("t6_async", 512'({s_valid, s_rdy, s_beat, s_done}), 512'({1'b0, 1'b1, 2'd0, 16'd0}));
    @(negedge clk) reset = 1'b0;
    step(); step();
    chk("t6_quiet", 512'(s_valid), 512'(1'b0));
    din = mk_tile(9); dwid = 4'd10; vin = 1'b1;
    step(); vin = 1'b0;
    for (int b = 0; b < 4; b++) begin chk_beat("t6_new", 9, 10, b, 1, 4); step(); end
    chk("t6_idle_done", 512'({s_valid, s_done}), 512'({1'b0, 16'd1}));

    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;

    // streaming at full rate for each beat width
    for (int s = 0; s < 3; s++) begin
      int n;
      int rows;
      n = 4 >> s;
      rows = 4 / n;
      sel = s;
      #1;
      for (int i = 0; i < 100; i++) begin
        din = mk_tile(100 + i); dwid = 4'(i % 16); vin = 1'b1;
        for (int b = 0; b < n; b++) begin
          if (b == 0) chk("st_rdy", 512'(s_rdy), 512'(1'b1));
          step();
          if (b == 0) vin = 1'b0;
          chk_beat("st", 100 + i, i % 16, b, rows, n);
        end
      end
      step();
      chk("st_idle_done", 512'({s_valid, s_done}), 512'({1'b0, 16'd100}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
